// File: rtl/reaction_round_ctrl.sv
// One reaction-game round: random pre-light delay, lit reaction count, then a hold phase.
// Ticks and presses are rising edges detected against registered copies of slow_clk and btn.
module reaction_round_ctrl #(
  parameter int DELAY_MIN  = 100,
  parameter int DELAY_MASK = 255,
  parameter int RESULT_W   = 10,
  parameter int TIMEOUT    = 999,
  parameter int HOLD       = 300
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                slow_clk,
  input  logic                start,
  input  logic                btn,
  output logic                led_on,
  output logic                busy,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic                foul,
  output logic                timeout
);

  localparam int DLY_W  = $clog2(DELAY_MIN + DELAY_MASK + 1);
  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam logic [7:0] MASK8 = 8'(DELAY_MASK);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_LIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_slow_d;
  logic                r_btn_d;
  logic [15:0]         r_lfsr;
  logic [DLY_W-1:0]    r_delay_cnt;
  logic [RESULT_W-1:0] r_react_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic             w_tick;
  logic             w_press;
  logic             w_lfsr_fb;
  logic             w_react_max;
  logic             w_hold_last;
  logic             w_delay_last;
  logic [DLY_W-1:0] w_delay_load;

  assign w_tick       = slow_clk & ~r_slow_d;
  assign w_press      = btn & ~r_btn_d;
  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_react_max  = (r_react_cnt == RESULT_W'(TIMEOUT));
  assign w_hold_last  = (r_hold_cnt == HOLD_W'(HOLD - 1));
  assign w_delay_last = (r_delay_cnt == DLY_W'(1));
  assign w_delay_load = DLY_W'(DELAY_MIN) + DLY_W'(r_lfsr[7:0] & MASK8);

  // Decoded from state so the LED drops in the same cycle as an async reset.
  assign led_on = (r_state == S_LIT);
  assign busy   = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_DELAY;
      S_DELAY: begin
        if (w_press)                     w_state_nxt = S_DONE;
        else if (w_tick && w_delay_last) w_state_nxt = S_LIT;
      end
      S_LIT: begin
        if (w_press)                    w_state_nxt = S_DONE;
        else if (w_tick && w_react_max) w_state_nxt = S_DONE;
      end
      S_DONE:  if (w_tick && w_hold_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_slow_d <= 1'b1;
      r_btn_d  <= 1'b1;
      r_lfsr   <= 16'hACE1;
    end else begin
      r_state  <= w_state_nxt;
      r_slow_d <= slow_clk;
      r_btn_d  <= btn;
      r_lfsr   <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_delay_cnt  <= '0;
      r_react_cnt  <= '0;
      r_hold_cnt   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_delay_cnt  <= w_delay_load;
            r_react_cnt  <= '0;
            r_hold_cnt   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
          end
        end
        S_DELAY: begin
          // A press wins over a coincident tick.
          if (w_press) begin
            foul <= 1'b1;
          end else if (w_tick) begin
            if (w_delay_last) r_react_cnt <= '0;
            else              r_delay_cnt <= r_delay_cnt - DLY_W'(1);
          end
        end
        S_LIT: begin
          if (w_press) begin
            result       <= r_react_cnt;
            result_valid <= 1'b1;
          end else if (w_tick) begin
            if (w_react_max) begin
              timeout <= 1'b1;
              result  <= RESULT_W'(TIMEOUT);
            end else begin
              r_react_cnt <= r_react_cnt + RESULT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (w_tick) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with short delays (DELAY_MIN=3, mask 0, TIMEOUT=20, HOLD=2).
// slow_clk is driven with a 10-cycle period (5 high, 5 low); inputs change 1 ns after the rising clock edge.
module tb_reaction_round_ctrl;

  localparam int RW = 10;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          slow_clk = 1'b0;
  logic          start = 1'b0;
  logic          btn = 1'b0;
  logic          led_on;
  logic          busy;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          foul;
  logic          timeout;

  int checks = 0;
  int failures = 0;
  int ph = 5;

  reaction_round_ctrl #(
    .DELAY_MIN (3),
    .DELAY_MASK(0),
    .RESULT_W  (RW),
    .TIMEOUT   (20),
    .HOLD      (2)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .slow_clk    (slow_clk),
    .start       (start),
    .btn         (btn),
    .led_on      (led_on),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .foul        (foul),
    .timeout     (timeout)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", tag, got, exp);
    end
  endtask

  // One clock, then advance the slow_clk phase; outputs are stable here.
  task automatic cyc();
    @(posedge clk_in);
    #1;
    ph = (ph + 1) % 10;
    slow_clk = (ph < 5);
  endtask

  // Advance until slow_clk has just risen: the DUT sees a tick in the current cycle.
  task automatic to_tick();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (ph != 0 && n < 20);
    if (ph != 0) chk("tick_bound", 32'(ph), 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      to_tick();
      cyc();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic press();
    btn = 1'b1;
    cyc();
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_led", 32'(led_on), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_foul", 32'(foul), 0);
    chk("rst_timeout", 32'(timeout), 0);
    rst = 1'b1;
    cyc();

    // Normal round: press 5 ticks after the LED lights.
    pulse_start();
    chk("n_busy", 32'(busy), 1);
    chk("n_led0", 32'(led_on), 0);
    ticks(2);
    chk("n_led_before3", 32'(led_on), 0);
    ticks(1);
    chk("n_led_after3", 32'(led_on), 1);
    ticks(5);
    press();
    chk("n_result", 32'(result), 5);
    chk("n_valid", 32'(result_valid), 1);
    chk("n_foul", 32'(foul), 0);
    chk("n_timeout", 32'(timeout), 0);
    chk("n_led_off", 32'(led_on), 0);
    chk("n_done_busy", 32'(busy), 1);
    btn = 1'b0;
    ticks(1);
    chk("n_hold1_busy", 32'(busy), 1);
    ticks(1);
    chk("n_idle", 32'(busy), 0);
    chk("n_result_held", 32'(result), 5);

    // Foul: press one tick into the delay.
    pulse_start();
    chk("f_cleared", 32'(result_valid), 0);
    ticks(1);
    press();
    btn = 1'b0;
    chk("f_foul", 32'(foul), 1);
    chk("f_led", 32'(led_on), 0);
    chk("f_valid", 32'(result_valid), 0);
    chk("f_result", 32'(result), 0);
    ticks(2);
    chk("f_idle", 32'(busy), 0);
    chk("f_led_end", 32'(led_on), 0);

    // Timeout: no press at all.
    pulse_start();
    ticks(3);
    chk("t_led", 32'(led_on), 1);
    ticks(20);
    chk("t_still_lit", 32'(led_on), 1);
    chk("t_no_to_yet", 32'(timeout), 0);
    ticks(1);
    chk("t_timeout", 32'(timeout), 1);
    chk("t_result", 32'(result), 20);
    chk("t_led_off", 32'(led_on), 0);
    chk("t_valid", 32'(result_valid), 0);
    chk("t_foul", 32'(foul), 0);
    ticks(2);
    chk("t_idle", 32'(busy), 0);

    // Press coincident with a LIT tick after 7 counted ticks.
    pulse_start();
    ticks(3);
    ticks(7);
    to_tick();
    press();
    btn = 1'b0;
    chk("c_lit_result", 32'(result), 7);
    chk("c_lit_valid", 32'(result_valid), 1);
    ticks(2);

    // Press coincident with the final DELAY tick.
    pulse_start();
    ticks(2);
    to_tick();
    press();
    btn = 1'b0;
    chk("c_dly_foul", 32'(foul), 1);
    chk("c_dly_led", 32'(led_on), 0);
    chk("c_dly_valid", 32'(result_valid), 0);
    ticks(2);

    // Start during DELAY and DONE is ignored.
    pulse_start();
    ticks(1);
    pulse_start();
    ticks(2);
    chk("i_lit_no_restart", 32'(led_on), 1);
    ticks(1);
    press();
    btn = 1'b0;
    chk("i_result", 32'(result), 1);
    pulse_start();
    chk("i_done_busy", 32'(busy), 1);
    chk("i_done_valid", 32'(result_valid), 1);
    ticks(2);
    chk("i_idle", 32'(busy), 0);

    // Button held across start: no foul; release and re-press in LIT.
    btn = 1'b1;
    cyc();
    pulse_start();
    chk("h_busy", 32'(busy), 1);
    ticks(3);
    chk("h_led", 32'(led_on), 1);
    chk("h_nofoul", 32'(foul), 0);
    btn = 1'b0;
    cyc();
    ticks(2);
    press();
    btn = 1'b0;
    chk("h_result", 32'(result), 2);
    chk("h_valid", 32'(result_valid), 1);
    chk("h_foul", 32'(foul), 0);
    ticks(2);

    // Async reset in the middle of LIT.
    pulse_start();
    ticks(4);
    chk("r_led_before", 32'(led_on), 1);
    rst = 1'b0;
    #1;
    chk("r_led_async", 32'(led_on), 0);
    chk("r_busy_async", 32'(busy), 0);
    chk("r_flags", 32'({result_valid, foul, timeout}), 0);
    slow_clk = 1'b1;
    btn = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b1;
    ph = 1;
    cyc();
    chk("r_rel_busy", 32'(busy), 0);
    chk("r_rel_flags", 32'({result_valid, foul, timeout}), 0);
    pulse_start();
    chk("r_round_busy", 32'(busy), 1);
    ticks(3);
    chk("r_round_led", 32'(led_on), 1);
    chk("r_round_nofoul", 32'(foul), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
